// File: rtl/ssp_pkg.sv
// Shared types and helpers for the second-generation synchronous serial port.
package ssp_pkg;

   typedef enum logic [1:0] {IDLE, FRAME, SHIFT} tx_state_t;
   typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Synchronous FIFO with show-ahead read data and occupancy level.
module ssp_fifo
   import ssp_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = level_width(FIFO_DEPTH)
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LVL_W'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A simultaneous pop lets a push land at full; callers that must not
   // rely on that gate push themselves.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ssp_gen2.sv
// Synchronous serial port: bus-side TX/RX FIFOs, serial clock divider,
// framed transmitter and receiver with optional internal loopback.
//
// state   | meaning
// IDLE    | transmitter waiting for a word and a falling serial edge
// FRAME   | SSPFSSOUT high for one bit period ahead of the data
// SHIFT   | driving data bits; may pre-load the next word on the last bit
// R_IDLE  | receiver waiting for a rise with frame sync high
// R_SHIFT | sampling DATA_W bits, one per rising serial clock
module ssp_gen2
   import ssp_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 1,
   parameter int LSB_FIRST  = 0,
   parameter int LVL_W      = level_width(FIFO_DEPTH)
) (
   input  logic              PCLK,
   input  logic              CLEAR_B,
   input  logic              PSEL,
   input  logic              PWRITE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   input  logic              LOOPBACK,
   input  logic              SSPCLKIN,
   input  logic              SSPFSSIN,
   input  logic              SSPRXD,
   output logic              SSPCLKOUT,
   output logic              SSPFSSOUT,
   output logic              SSPTXD,
   output logic              SSPOE_B,
   output logic              SSPTXINTR,
   output logic              SSPRXINTR,
   output logic              RXOVR,
   output logic [LVL_W-1:0]  TXLEVEL,
   output logic [LVL_W-1:0]  RXLEVEL
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   function automatic logic lead_bit(input logic [DATA_W-1:0] w);
      return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] drop_lead(input logic [DATA_W-1:0] w);
      return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   logic [DIV_W-1:0]  div_cnt;
   logic              sclk;
   logic              fall_evt;

   tx_state_t         tx_state;
   logic [DATA_W-1:0] tx_sh;
   logic [CNT_W-1:0]  tx_cnt;
   logic              tx_next;
   logic              fss_out;
   logic              txd_out;
   logic              oe_b;

   rx_state_t         rx_state;
   logic [DATA_W-1:0] rx_sh;
   logic [CNT_W-1:0]  rx_cnt;
   logic              rx_prev;
   logic              rx_push;
   logic              src_clk;
   logic              src_fss;
   logic              src_dat;
   logic              rise;

   logic              rd_req;
   logic              tx_push;
   logic              tx_pop;
   logic              tx_full;
   logic              tx_empty;
   logic [DATA_W-1:0] tx_rdata;
   logic              rx_full;
   logic              rx_empty;
   logic [DATA_W-1:0] rx_rdata;
   logic              ovr_evt;

   assign fall_evt = (div_cnt == DIV_LAST) & sclk;

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Pops happen only when starting from idle or when the last bit of the
   // current word goes out, so the shift register is always free to reload.
   assign tx_pop = fall_evt & ~tx_empty &
                   ((tx_state == IDLE) | ((tx_state == SHIFT) & (tx_cnt == CNT_W'(1))));
   assign tx_push = PSEL & PWRITE & ~tx_full;

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         tx_state <= IDLE;
         tx_sh    <= '0;
         tx_cnt   <= '0;
         tx_next  <= 1'b0;
         fss_out  <= 1'b0;
         txd_out  <= 1'b0;
         oe_b     <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               if (tx_pop) begin
                  tx_sh    <= tx_rdata;
                  fss_out  <= 1'b1;
                  tx_state <= FRAME;
               end
            end
            FRAME: begin
               if (fall_evt) begin
                  fss_out  <= 1'b0;
                  oe_b     <= 1'b0;
                  txd_out  <= lead_bit(tx_sh);
                  tx_sh    <= drop_lead(tx_sh);
                  tx_cnt   <= CNT_LAST;
                  tx_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (fall_evt) begin
                  if (tx_cnt != '0) begin
                     txd_out <= lead_bit(tx_sh);
                     tx_sh   <= drop_lead(tx_sh);
                     tx_cnt  <= tx_cnt - 1'b1;
                     if (tx_pop) begin
                        tx_sh   <= tx_rdata;
                        fss_out <= 1'b1;
                        tx_next <= 1'b1;
                     end
                  end else if (tx_next) begin
                     fss_out <= 1'b0;
                     txd_out <= lead_bit(tx_sh);
                     tx_sh   <= drop_lead(tx_sh);
                     tx_cnt  <= CNT_LAST;
                     tx_next <= 1'b0;
                  end else begin
                     oe_b     <= 1'b1;
                     txd_out  <= 1'b0;
                     tx_state <= IDLE;
                  end
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   assign src_clk = LOOPBACK ? sclk    : SSPCLKIN;
   assign src_fss = LOOPBACK ? fss_out : SSPFSSIN;
   assign src_dat = LOOPBACK ? txd_out : SSPRXD;
   assign rise    = src_clk & ~rx_prev;

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         rx_state <= R_IDLE;
         rx_sh    <= '0;
         rx_cnt   <= '0;
         rx_prev  <= 1'b0;
         rx_push  <= 1'b0;
      end else begin
         rx_prev <= src_clk;
         rx_push <= 1'b0;
         case (rx_state)
            R_IDLE: begin
               if (rise & src_fss) begin
                  rx_cnt   <= CNT_LAST;
                  rx_state <= R_SHIFT;
               end
            end
            R_SHIFT: begin
               if (rise) begin
                  rx_sh <= shift_in(rx_sh, src_dat);
                  if (rx_cnt == '0) begin
                     rx_push <= 1'b1;
                     rx_cnt  <= CNT_LAST;
                     if (!src_fss) rx_state <= R_IDLE;
                  end else begin
                     rx_cnt <= rx_cnt - 1'b1;
                  end
               end
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   assign rd_req  = PSEL & ~PWRITE;
   assign ovr_evt = rx_push & rx_full & ~rd_req;

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         PRDATA <= '0;
         RXOVR  <= 1'b0;
      end else begin
         if (rd_req) PRDATA <= rx_empty ? '0 : rx_rdata;
         if (ovr_evt)     RXOVR <= 1'b1;
         else if (rd_req) RXOVR <= 1'b0;
      end
   end

   ssp_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
      .clk_sys (PCLK),
      .rst_n   (CLEAR_B),
      .push    (tx_push),
      .pop     (tx_pop),
      .wdata   (PWDATA),
      .rdata   (tx_rdata),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (TXLEVEL)
   );

   ssp_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
      .clk_sys (PCLK),
      .rst_n   (CLEAR_B),
      .push    (rx_push),
      .pop     (rd_req),
      .wdata   (rx_sh),
      .rdata   (rx_rdata),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (RXLEVEL)
   );

   assign SSPCLKOUT = sclk;
   assign SSPFSSOUT = fss_out;
   assign SSPTXD    = txd_out;
   assign SSPOE_B   = oe_b;
   assign SSPTXINTR = tx_full;
   assign SSPRXINTR = rx_full;

endmodule

// File: tb/tb_ssp_gen2.sv
// Randomised self-checking bench for ssp_gen2: default instance plus a
// divide-by-3, LSB-first instance in loopback.
module tb_ssp_gen2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       psel, pwrite, loopback, clkin, fssin, rxd;
   logic [7:0] pwdata, prdata;
   logic       sclk, fss, txd, oe_b, txintr, rxintr, rxovr;
   logic [2:0] txlvl, rxlvl;

   logic       psel2, pwrite2;
   logic [7:0] pwdata2, prdata2;
   logic       sclk2, fss2, txd2, oe_b2, txintr2, rxintr2, rxovr2;
   logic [2:0] txlvl2, rxlvl2;

   ssp_gen2 u_dut (
      .PCLK(clk), .CLEAR_B(rst_n), .PSEL(psel), .PWRITE(pwrite), .PWDATA(pwdata),
      .PRDATA(prdata), .LOOPBACK(loopback), .SSPCLKIN(clkin), .SSPFSSIN(fssin),
      .SSPRXD(rxd), .SSPCLKOUT(sclk), .SSPFSSOUT(fss), .SSPTXD(txd), .SSPOE_B(oe_b),
      .SSPTXINTR(txintr), .SSPRXINTR(rxintr), .RXOVR(rxovr), .TXLEVEL(txlvl),
      .RXLEVEL(rxlvl)
   );

   ssp_gen2 #(.CLK_DIV(3), .LSB_FIRST(1)) u_div3 (
      .PCLK(clk), .CLEAR_B(rst_n), .PSEL(psel2), .PWRITE(pwrite2), .PWDATA(pwdata2),
      .PRDATA(prdata2), .LOOPBACK(1'b1), .SSPCLKIN(1'b0), .SSPFSSIN(1'b0),
      .SSPRXD(1'b0), .SSPCLKOUT(sclk2), .SSPFSSOUT(fss2), .SSPTXD(txd2), .SSPOE_B(oe_b2),
      .SSPTXINTR(txintr2), .SSPRXINTR(rxintr2), .RXOVR(rxovr2), .TXLEVEL(txlvl2),
      .RXLEVEL(rxlvl2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic c_clk [0:199];
   logic c_fss [0:199];
   logic c_txd [0:199];
   logic c_oe  [0:199];

   task automatic cap0(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c_clk[i] = sclk; c_fss[i] = fss; c_txd[i] = txd; c_oe[i] = oe_b;
      end
   endtask

   task automatic cap1(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c_clk[i] = sclk2; c_fss[i] = fss2; c_txd[i] = txd2; c_oe[i] = oe_b2;
      end
   endtask

   task automatic write0(input logic [7:0] d);
      psel = 1'b1; pwrite = 1'b1; pwdata = d;
      @(negedge clk);
      psel = 1'b0;
   endtask

   task automatic read0(output logic [7:0] d);
      psel = 1'b1; pwrite = 1'b0;
      @(negedge clk);
      psel = 1'b0;
      d = prdata;
   endtask

   task automatic wait_rx0(input int n, input int budget, input string tag);
      int k = 0;
      while (rxlvl < 3'(n) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, rxlvl, n);
   endtask

   task automatic ext_bit(input logic f, input logic d);
      fssin = f; rxd = d; clkin = 1'b0;
      repeat (2) @(negedge clk);
      clkin = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Bit b of a word in shift order (b=0 goes out first).
   function automatic logic ser_bit(input logic [7:0] w, input int b, input bit lsb_first);
      return lsb_first ? w[b] : w[7-b];
   endfunction

   int  oe_run = 0, oe_max = 0, ovl = 0;
   bit  mon_en = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (!oe_b) oe_run++;
         else begin
            if (oe_run > oe_max) oe_max = oe_run;
            oe_run = 0;
         end
         if (fss && !oe_b) ovl++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, w;
      logic [7:0] exp_q [$];
      logic [7:0] wv [5];
      int f0, len, r0, r1, got;

      rst_n = 1'b0; psel = 0; pwrite = 0; pwdata = 0; loopback = 1'b1;
      clkin = 0; fssin = 0; rxd = 0; psel2 = 0; pwrite2 = 0; pwdata2 = 0;
      repeat (3) @(negedge clk);
      chk("rst_prdata", prdata, 0);   chk("rst_sclk", sclk, 0);
      chk("rst_fss", fss, 0);         chk("rst_txd", txd, 0);
      chk("rst_oe_b", oe_b, 1);       chk("rst_txintr", txintr, 0);
      chk("rst_rxintr", rxintr, 0);   chk("rst_rxovr", rxovr, 0);
      chk("rst_txlvl", txlvl, 0);     chk("rst_rxlvl", rxlvl, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single word 0xA5 in loopback, check waveform
      write0(8'hA5);
      cap0(40);
      f0 = -1;
      for (int i = 0; i < 40; i++) if (c_fss[i] && f0 < 0) f0 = i;
      chk("a5_fss_seen", (f0 >= 0), 1);
      if (f0 < 0) f0 = 0;
      len = 0;
      for (int i = f0; i < 40 && c_fss[i]; i++) len++;
      chk("a5_fss_len", len, 2);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("a5_bit%0d_a", b), c_txd[f0+2+2*b], ser_bit(8'hA5, b, 0));
         chk($sformatf("a5_bit%0d_b", b), c_txd[f0+3+2*b], ser_bit(8'hA5, b, 0));
      end
      len = 0;
      for (int i = 0; i < 40; i++) if (!c_oe[i]) len++;
      chk("a5_oe_low_len", len, 16);
      chk("a5_oe_first", c_oe[f0+2], 0);
      chk("a5_oe_after", c_oe[f0+18], 1);
      wait_rx0(1, 20, "a5_rxlvl");
      read0(d);
      chk("a5_data", d, 8'hA5);
      chk("a5_rxlvl_after", rxlvl, 0);

      read0(d);
      chk("empty_read_data", d, 0);
      chk("empty_read_lvl", rxlvl, 0);

      // burst of six writes: first pops straight away, four fill FIFO, sixth dropped
      oe_run = 0; oe_max = 0; ovl = 0; mon_en = 1;
      psel = 1'b1; pwrite = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pwdata = 8'(8'h11 * (i + 1));
         if (i < 5) exp_q.push_back(pwdata);
         @(negedge clk);
         if (i == 4) begin
            chk("burst_txintr", txintr, 1);
            chk("burst_txlvl_full", txlvl, 4);
         end
      end
      psel = 1'b0;
      chk("burst_drop_txlvl", txlvl, 4);
      got = 0;
      for (int c = 0; c < 300 && got < 5; c++) begin
         if (rxlvl != 0) begin
            read0(d);
            chk($sformatf("burst_data%0d", got), d, exp_q.pop_front());
            got++;
         end else @(negedge clk);
      end
      chk("burst_count", got, 5);
      repeat (10) @(negedge clk);
      mon_en = 0;
      chk("burst_oe_run", oe_max, 80);
      chk("burst_fss_overlap", ovl, 8);
      chk("burst_rxovr", rxovr, 0);
      chk("burst_txlvl_end", txlvl, 0);

      // overrun: five random words, no reads
      psel = 1'b1; pwrite = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wv[i] = 8'($urandom);
         pwdata = wv[i];
         @(negedge clk);
      end
      psel = 1'b0;
      repeat (120) @(negedge clk);
      chk("ovr_rxlvl", rxlvl, 4);
      chk("ovr_rxintr", rxintr, 1);
      chk("ovr_flag", rxovr, 1);
      read0(d);
      chk("ovr_first", d, wv[0]);
      chk("ovr_cleared", rxovr, 0);
      chk("ovr_rxintr_drop", rxintr, 0);
      chk("ovr_rxlvl_3", rxlvl, 3);
      for (int i = 1; i < 4; i++) begin
         read0(d);
         chk($sformatf("ovr_word%0d", i), d, wv[i]);
      end

      // random single words with random idle gaps
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         w = 8'($urandom);
         write0(w);
         wait_rx0(1, 60, "rand_rxlvl");
         read0(d);
         chk($sformatf("rand_word%0d", k), d, w);
      end

      // external peer on the pins
      loopback = 1'b0;
      repeat (4) @(negedge clk);
      ext_bit(1, 0);
      for (int b = 0; b < 8; b++) ext_bit(0, ser_bit(8'h3C, b, 0));
      ext_bit(0, 0);
      chk("ext_rxlvl", rxlvl, 1);
      read0(d);
      chk("ext_3c", d, 8'h3C);

      w = 8'($urandom);
      ext_bit(1, 0);
      for (int b = 0; b < 8; b++) ext_bit(b < 3, ser_bit(w, b, 0));
      ext_bit(0, 0);
      chk("ext_drop_rxlvl", rxlvl, 1);
      read0(d);
      chk("ext_drop_word", d, w);

      wv[0] = 8'($urandom); wv[1] = 8'($urandom);
      ext_bit(1, 0);
      for (int b = 0; b < 8; b++) ext_bit(b == 7, ser_bit(wv[0], b, 0));
      for (int b = 0; b < 8; b++) ext_bit(0, ser_bit(wv[1], b, 0));
      ext_bit(0, 0);
      chk("ext_b2b_rxlvl", rxlvl, 2);
      read0(d);
      chk("ext_b2b_w0", d, wv[0]);
      read0(d);
      chk("ext_b2b_w1", d, wv[1]);
      loopback = 1'b1;

      // divide-by-3 LSB-first instance
      psel2 = 1'b1; pwrite2 = 1'b1; pwdata2 = 8'h01;
      @(negedge clk);
      psel2 = 1'b0;
      cap1(80);
      r0 = -1; r1 = -1;
      for (int i = 1; i < 80; i++)
         if (c_clk[i] && !c_clk[i-1]) begin
            if (r0 < 0) r0 = i;
            else if (r1 < 0) r1 = i;
         end
      chk("div3_period", r1 - r0, 6);
      f0 = -1;
      for (int i = 0; i < 80; i++) if (c_fss[i] && f0 < 0) f0 = i;
      chk("div3_fss_seen", (f0 >= 0), 1);
      if (f0 < 0) f0 = 0;
      len = 0;
      for (int i = f0; i < 80 && c_fss[i]; i++) len++;
      chk("div3_fss_len", len, 6);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("div3_bit%0d_a", b), c_txd[f0+6+6*b], ser_bit(8'h01, b, 1));
         chk($sformatf("div3_bit%0d_b", b), c_txd[f0+11+6*b], ser_bit(8'h01, b, 1));
      end
      begin
         int k = 0;
         while (rxlvl2 == 0 && k < 40) begin @(negedge clk); k++; end
      end
      chk("div3_rxlvl", rxlvl2, 1);
      psel2 = 1'b1; pwrite2 = 1'b0;
      @(negedge clk);
      psel2 = 1'b0;
      chk("div3_data", prdata2, 8'h01);

      // asynchronous reset in the middle of a frame
      write0(8'($urandom | 1));
      repeat (8) @(negedge clk);
      chk("midrst_oe_before", oe_b, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_oe_b", oe_b, 1);     chk("midrst_fss", fss, 0);
      chk("midrst_txd", txd, 0);       chk("midrst_sclk", sclk, 0);
      chk("midrst_prdata", prdata, 0); chk("midrst_prdata2", prdata2, 0);
      chk("midrst_txlvl", txlvl, 0);   chk("midrst_rxlvl", rxlvl, 0);
      chk("midrst_rxovr", rxovr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_partial", rxlvl, 0);
      chk("midrst_oe_idle", oe_b, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
